fifo_wptr_ctrl: RTL and testbench
=================================

// Module: fifo_wptr_ctrl
// PURPOSE
//  Write-domain pointer/control stage of the async CDC FIFO. Generates binary write
//  address + Gray write pointer, synchronises the read-domain Gray pointer into clk,
//  and gates writes to the dual-port RAM. Feeds wptr/wq2_rptr to the write-side full
//  flag register; also provides fill level, almost_full and sticky overflow.
// PARAMETERS
//  ADDRSIZE     8                   RAM address width; depth = 2**ADDRSIZE; pointers ADDRSIZE+1 bits
//  SYNC_STAGES  2                   flops in rptr synchroniser chain (legal >= 2)
//  AF_THRESH    (2**ADDRSIZE)-4     wr_level at/above which almost_full asserts
// PORTS
//  clk        in   1           write-domain clock
//  rst_n      in   1           reset, asynchronous, active-low
//  winc       in   1           write request (data presented to RAM same cycle)
//  rptr_gray  in   ADDRSIZE+1  Gray read pointer from read domain (async)
//  clr_ovf    in   1           clears overflow sticky bit
//  wen        out  1           RAM write enable (combinational)
//  waddr      out  ADDRSIZE    RAM write address = wbin[ADDRSIZE-1:0]
//  wptr       out  ADDRSIZE+1  registered Gray write pointer (to read domain + full flag)
//  wq2_rptr   out  ADDRSIZE+1  synchronised Gray read pointer (to full flag)
//  wr_level   out  ADDRSIZE+1  registered fill level, write-domain view
//  almost_full out 1           registered, wr_level >= AF_THRESH
//  overflow   out  1           sticky: write attempted while full
// BEHAVIOUR
//  - Reset: wbin, wptr, all sync flops, wq2_rptr, wr_level, almost_full, overflow = 0.
//    Reset is asynchronous assert; both FIFO domains must be reset together.
//  - full_now (internal, comb) = (wptr == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), A=ADDRSIZE.
//  - wen = winc & ~full_now. Writes are gated here, never by the registered full flag
//    (that flag lags one cycle and must not be relied on to block a write).
//  - On wen: wbin <= wbin+1 (mod 2**(A+1)); wptr <= bin2gray(wbin+1). Else both hold.
//    waddr valid in the same cycle as wen; 0 write latency to RAM.
//  - wptr changes at most one bit per clk (Gray); only wptr crosses domains.
//  - Synchroniser: rptr_gray -> SYNC_STAGES flops -> wq2_rptr; latency = SYNC_STAGES edges.
//  - wr_level <= wbin - gray2bin(wq2_rptr), mod 2**(A+1), using current registered
//    values (one-cycle lag vs wbin). Range 0..2**A. Pessimistic by design (stale rptr).
//  - almost_full <= (that same difference >= AF_THRESH); same cycle as wr_level.
//  - overflow: set when winc & full_now; cleared when clr_ovf; set wins if both same cycle.
//  - Wrap: pointer MSB toggles each pass; full only when MSB and MSB-1 differ, rest equal.
//  - winc while full: no RAM write, pointers hold, overflow set; no other side effect.
// STRUCTURE
//  - Package fifo_cdc_pkg: ADDRSIZE default, functions bin2gray(), gray2bin()
//    (width ADDRSIZE+1), shared with read-pointer control and full/empty flag blocks.
//  - Sub-module cdc_sync_vec #(WIDTH, STAGES): reset-to-0 flop chain, ASYNC_REG
//    attributes; reused by the read side for wptr.
//  - Top: binary/Gray counter, full_now compare, level/almost_full regs, overflow reg.
// TESTING  (ADDRSIZE=8, SYNC_STAGES=2, AF_THRESH=252)
//  1 Reset mid-burst after 10 writes -> all outputs 0 during and after reset, wptr=9'h000.
//  2 rptr_gray=0, winc high 256 cycles -> 256 wen pulses, waddr 0..255, wptr=9'h180,
//    full_now true, wr_level=256 one cycle later, almost_full set when level reaches 252.
//  3 Continue winc at full -> wen=0, wptr holds 9'h180, overflow=1; clr_ovf with winc
//    still high -> overflow stays 1; clr_ovf with winc low -> overflow=0.
//  4 Step rptr_gray 0->9'h001 -> wq2_rptr updates exactly 2 clk edges later; full_now
//    drops, next winc writes addr 0, wptr becomes 9'h181 (gray of 257).
//  5 Wrap: drive rptr in step with writes across 600 writes -> wbin wraps 511->0,
//    wptr one-bit-change checked every increment, wr_level never exceeds 256.
//  6 Random winc/rptr (Gray-legal steps) vs scoreboard model -> wen, wr_level,
//    almost_full match cycle-exactly; no write accepted when model is full.

Source files
------------

// File: rtl/fifo_cdc_pkg.sv
// Shared definitions for the async CDC FIFO: default geometry and Gray/binary
// pointer conversions used by both pointer-control blocks and the flag logic.
package fifo_cdc_pkg;

  localparam int DEF_ADDRSIZE = 8;
  localparam int PTR_WIDE     = 32;

  // Conversions operate on a zero-extended wide vector, so any pointer width
  // up to PTR_WIDE can share them without a per-width copy.
  typedef logic [PTR_WIDE-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
    ptr_wide_t bin;
    bin = gray;
    for (int i = 1; i < PTR_WIDE; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_sync_vec.sv
// Multi-flop synchroniser for a Gray-coded vector crossing into the clk domain.
// Only one bit of d may change per source update for the output to be coherent.
module cdc_sync_vec #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_r [STAGES];

  // Synchroniser chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer/control for the async CDC FIFO: binary/Gray write pointer,
// read-pointer synchronisation, write gating, fill level, almost_full and overflow.
module fifo_wptr_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter int ADDRSIZE    = DEF_ADDRSIZE,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = (2**ADDRSIZE) - 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_gray,
  input  logic                clr_ovf,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wr_level,
  output logic                almost_full,
  output logic                overflow
);

  localparam int PTRW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] wptr_r;
  logic [ADDRSIZE:0] wq2_rptr_s;
  logic [ADDRSIZE:0] wbin_next_s;
  logic [ADDRSIZE:0] wptr_next_s;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] diff_s;
  logic [ADDRSIZE:0] full_cmp_s;
  logic              full_now_s;
  logic              wen_s;
  logic [ADDRSIZE:0] wr_level_r;
  logic              almost_full_r;
  logic              overflow_r;

  cdc_sync_vec #(
    .WIDTH  (PTRW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rptr_gray),
    .q     (wq2_rptr_s)
  );

  // Next-pointer, full compare, write gate and write-side level difference.
  always_comb begin
    wbin_next_s = wbin_r + PTRW'(1);
    wptr_next_s = PTRW'(bin2gray(ptr_wide_t'(wbin_next_s)));
    rbin_s      = PTRW'(gray2bin(ptr_wide_t'(wq2_rptr_s)));
    diff_s      = wbin_r - rbin_s;
    // Full: write pointer is exactly one lap ahead, which in Gray means the
    // top two bits are inverted and the rest match.
    full_cmp_s  = {~wq2_rptr_s[ADDRSIZE:ADDRSIZE-1], wq2_rptr_s[ADDRSIZE-2:0]};
    full_now_s  = (wptr_r == full_cmp_s);
    wen_s       = winc & ~full_now_s;
  end

  // Binary and Gray write pointers advance together on an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_r <= '0;
      wptr_r <= '0;
    end else if (wen_s) begin
      wbin_r <= wbin_next_s;
      wptr_r <= wptr_next_s;
    end
  end

  // Level and almost_full from the stale synchronised read pointer (pessimistic).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_level_r    <= '0;
      almost_full_r <= 1'b0;
    end else begin
      wr_level_r    <= diff_s;
      almost_full_r <= (diff_s >= PTRW'(AF_THRESH));
    end
  end

  // Sticky overflow; a new overflow in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (winc & full_now_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end
  end

  assign wen         = wen_s;
  assign waddr       = wbin_r[ADDRSIZE-1:0];
  assign wptr        = wptr_r;
  assign wq2_rptr    = wq2_rptr_s;
  assign wr_level    = wr_level_r;
  assign almost_full = almost_full_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Scoreboard bench for fifo_wptr_ctrl: a count-based model of writes/reads
// predicts each cycle's outputs; a monitor pops and compares them.
module tb_fifo_wptr_ctrl;

  localparam int AF = 252;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [8:0] rptr_gray = 9'd0;
  logic       wen;
  logic [7:0] waddr;
  logic [8:0] wptr;
  logic [8:0] wq2_rptr;
  logic [8:0] wr_level;
  logic       almost_full;
  logic       overflow;

  fifo_wptr_ctrl #(
    .ADDRSIZE    (8),
    .SYNC_STAGES (2),
    .AF_THRESH   (AF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .winc        (winc),
    .rptr_gray   (rptr_gray),
    .clr_ovf     (clr_ovf),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .wq2_rptr    (wq2_rptr),
    .wr_level    (wr_level),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic [7:0] waddr;
    logic [8:0] wptr;
    logic [8:0] wq2;
    logic [8:0] level;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: plain counts of accepted writes and issued reads; the write domain
  // sees the read count two clock edges late.
  int m_wcnt, m_s1, m_wq2, rcnt, m_level, acc_writes;
  bit m_af, m_ovf;
  logic [8:0] prev_wptr;
  bit prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [8:0] b2g(input int v);
    logic [8:0] b;
    b = v[8:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt = 0; m_s1 = 0; m_wq2 = 0; rcnt = 0; m_level = 0;
    m_af = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic cycle(input bit w, input bit radv, input bit clr);
    exp_t e;
    int   diff;
    bit   full;
    @(negedge clk);
    if (radv && rcnt < m_wcnt) rcnt++;
    winc = w;
    clr_ovf = clr;
    rptr_gray = b2g(rcnt);
    diff = m_wcnt - m_wq2;
    full = (diff == 256);
    e.wen   = w && !full;
    e.waddr = m_wcnt[7:0];
    e.wptr  = b2g(m_wcnt);
    e.wq2   = b2g(m_wq2);
    e.level = m_level[8:0];
    e.af    = m_af;
    e.ovf   = m_ovf;
    sb_q.push_back(e);
    m_level = diff;
    m_af = (diff >= AF);
    if (w && full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (e.wen) begin
      m_wcnt++;
      acc_writes++;
    end
    m_wq2 = m_s1;
    m_s1 = rcnt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wen"}, {31'd0, wen}, 32'd0);
    chk({tag, "_waddr"}, {24'd0, waddr}, 32'd0);
    chk({tag, "_wptr"}, {23'd0, wptr}, 32'd0);
    chk({tag, "_wq2"}, {23'd0, wq2_rptr}, 32'd0);
    chk({tag, "_level"}, {23'd0, wr_level}, 32'd0);
    chk({tag, "_af"}, {31'd0, almost_full}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  // Monitor: compares every presented cycle against the scoreboard entry.
  always @(negedge clk) begin : mon_blk
    exp_t me;
    #2;
    if (sb_q.size() > 0) begin
      me = sb_q.pop_front();
      chk("wen", {31'd0, wen}, {31'd0, me.wen});
      chk("waddr", {24'd0, waddr}, {24'd0, me.waddr});
      chk("wptr", {23'd0, wptr}, {23'd0, me.wptr});
      chk("wq2_rptr", {23'd0, wq2_rptr}, {23'd0, me.wq2});
      chk("wr_level", {23'd0, wr_level}, {23'd0, me.level});
      chk("almost_full", {31'd0, almost_full}, {31'd0, me.af});
      chk("overflow", {31'd0, overflow}, {31'd0, me.ovf});
      chk("level_max", {31'd0, (wr_level <= 9'd256)}, 32'd1);
      if (prev_valid && wptr !== prev_wptr)
        chk("wptr_gray_step", $countones(wptr ^ prev_wptr), 32'd1);
      prev_wptr = wptr;
      prev_valid = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, guard;
    acc_writes = 0;
    model_reset();
    #3;
    chk_all_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a burst.
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    #3;
    winc = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_during");
    prev_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill from empty with the read pointer parked at zero.
    repeat (256) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    #3;
    chk("full_wptr", {23'd0, wptr}, 32'h180);
    chk("full_wen_blocked", {31'd0, wen}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    #3;
    chk("full_level", {23'd0, wr_level}, 32'd256);
    chk("full_af", {31'd0, almost_full}, 32'd1);
    chk("full_ovf", {31'd0, overflow}, 32'd1);

    // Overflow clear: set wins while still writing into full.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    #3;
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    #3;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // One read: synchroniser latency then the freed slot is written.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    #3;
    chk("sync_one_edge", {23'd0, wq2_rptr}, 32'h000);
    cycle(1'b0, 1'b0, 1'b0);
    #3;
    chk("sync_two_edges", {23'd0, wq2_rptr}, 32'h001);
    cycle(1'b1, 1'b0, 1'b0);
    #3;
    chk("refill_wen", {31'd0, wen}, 32'd1);
    chk("refill_addr", {24'd0, waddr}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    #3;
    chk("refill_wptr", {23'd0, wptr}, 32'h181);

    // Streaming writes with reads keeping pace, across pointer wrap.
    target = acc_writes + 600;
    guard = 0;
    while (acc_writes < target && guard < 4000) begin
      cycle(1'b1, ($urandom_range(0, 3) != 0), 1'b0);
      guard++;
    end
    chk("wrap_writes_done", acc_writes >= target, 32'd1);

    // Fully random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #3;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
